ramp_adc_ctrl: RTL and testbench
================================

// Module: ramp_adc_ctrl
// PURPOSE
//  Ramp-compare ADC controller, downstream of the comparator synchronizer.
//  - Generates a stepped PWM ramp (pwm_out -> external RC filter -> comparator +).
//  - Latches the ramp code when the synchronized comparator rises (ramp > Vin).
//  - Publishes one conversion result per ramp, with over/underrange flags.
// PARAMETERS
//  CODE_WIDTH        8    ADC resolution; PWM period = 2**CODE_WIDTH clk.
//  STEP_PERIODS      4    PWM periods each ramp code is held (RC settling), >=1.
//  DISCHARGE_CYCLES  4096 clk cycles pwm_out forced 0 before each ramp, >=1.
// PORTS
//  clk                input   1           system clock
//  reset_n            input   1           asynchronous, active low
//  enable             input   1           1 = convert continuously
//  vcompare_sync      input   1           synchronized comparator level
//  low_to_high_pulse  input   1           1-clk pulse, comparator rose
//  pwm_out            output  1           registered PWM to RC ramp filter
//  ramp_code          output  CODE_WIDTH  current ramp step (debug)
//  adc_code           output  CODE_WIDTH  last conversion result, held
//  code_valid         output  1           1-clk pulse, adc_code updated
//  overrange          output  1           last result: no crossing, full scale
//  underrange         output  1           last result: comparator high at ramp start
//  busy               output  1           1 in DISCHARGE/RAMP/DONE
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; all outputs and counters 0.
//  PWM: pwm_cnt free-runs 0..2**W-1 while not IDLE.
//    pwm_out <= (pwm_cnt < ramp_code); code 0 -> always 0.
//    Duty = ramp_code / 2**W; max code = (2**W-1)/2**W.
//  States:
//   IDLE: pwm_out=0, ramp_code=0, busy=0. enable=1 -> DISCHARGE next clk.
//   DISCHARGE: ramp_code=0 for DISCHARGE_CYCLES clk, then RAMP.
//     pwm_cnt and period counter are cleared on RAMP entry.
//   RAMP: ramp_code advances +1 when pwm_cnt wraps on period STEP_PERIODS-1.
//    - 1st RAMP cycle with vcompare_sync=1:
//      adc_code<=0, underrange<=1, overrange<=0, code_valid, -> DONE.
//    - low_to_high_pulse:
//      adc_code<=ramp_code (value that cycle), both flags<=0, code_valid, -> DONE.
//    - Last step of code 2**W-1 ends with no pulse:
//      adc_code<=all ones, overrange<=1, underrange<=0, code_valid, -> DONE.
//    - Pulse coincides with the final step boundary: pulse wins, no overrange.
//    - Pulse on the 1st RAMP cycle with vcompare_sync=1: underrange wins.
//   DONE (1 clk): ramp_code<=0; enable=1 -> DISCHARGE, else -> IDLE.
//  enable sampled only in IDLE/DONE; a deassert mid-conversion completes it.
//  low_to_high_pulse ignored outside RAMP. No wrap of ramp_code past max.
//  code_valid: exactly 1 clk, registered, asserted in the DONE cycle.
//    adc_code/flags change only with code_valid.
//  Conversion time = DISCHARGE_CYCLES + 2**W*STEP_PERIODS*2**W clk (max).
//  Sync latency (3 clk) << step length; no correction applied.
// STRUCTURE
//  ramp_adc_pkg: typedef enum logic [1:0] {IDLE,DISCHARGE,RAMP,DONE} ramp_state_t.
//  Sub-module pwm_dac (pwm_cnt, compare, registered pwm_out, wrap strobe).
//    Controller uses the wrap strobe to step ramp_code.
// TESTING (CODE_WIDTH=4, STEP_PERIODS=2, DISCHARGE_CYCLES=16)
//  1 Pulse during step 9 -> adc_code=9, code_valid 1 clk, both flags 0.
//  2 No pulse, vcompare_sync=0 -> adc_code=15, overrange=1,
//      code_valid 512 clk after RAMP entry.
//  3 vcompare_sync=1 entering RAMP -> adc_code=0, underrange=1, code_valid next DONE.
//  4 ramp_code=5 -> pwm_out high exactly 5 of every 16 clk;
//      ramp_code=0 -> pwm_out never high.
//  5 enable 1->0 at step 3, pulse at step 7 -> adc_code=7, then IDLE,
//      busy=0, pwm_out=0.
//  6 reset_n low at step 6 (no clk edge) -> all outputs 0 immediately;
//      after release with enable=1 -> DISCHARGE, fresh ramp from 0.

Source files
------------

// File: rtl/ramp_adc_pkg.sv
// Shared types for the ramp-compare ADC controller.
package ramp_adc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    RAMP      = 2'd2,
    DONE      = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/pwm_dac.sv
// PWM generator for the RC ramp filter: free-running period counter, registered
// compare output and a combinational end-of-period strobe.
module pwm_dac #(
  parameter int CODE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  clear,
  input  logic                  active,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  pwm_out,
  output logic                  wrap
);

  logic [CODE_WIDTH-1:0] pwm_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (!run || clear) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      // Gated by active so the cycle leaving RAMP cannot leak a high into IDLE.
      pwm_out <= active && (pwm_cnt < code);
    end
  end

  assign wrap = run && (pwm_cnt == '1);

endmodule

// File: rtl/ramp_adc_ctrl.sv
// Ramp-compare ADC controller: discharge, stepped PWM ramp, latch the ramp code
// on the comparator's rising edge and publish one result per ramp.
module ramp_adc_ctrl
  import ramp_adc_pkg::*;
#(
  parameter int CODE_WIDTH       = 8,
  parameter int STEP_PERIODS     = 4,
  parameter int DISCHARGE_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  vcompare_sync,
  input  logic                  low_to_high_pulse,
  output logic                  pwm_out,
  output logic [CODE_WIDTH-1:0] ramp_code,
  output logic [CODE_WIDTH-1:0] adc_code,
  output logic                  code_valid,
  output logic                  overrange,
  output logic                  underrange,
  output logic                  busy
);

  localparam int PW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int DW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam logic [CODE_WIDTH-1:0] MAX_CODE = '1;
  localparam logic [PW-1:0] LAST_PERIOD = PW'(STEP_PERIODS - 1);
  localparam logic [DW-1:0] LAST_DISCHARGE = DW'(DISCHARGE_CYCLES - 1);

  ramp_state_t   state;
  logic [PW-1:0] per_cnt;
  logic [DW-1:0] dis_cnt;
  logic          first_ramp;
  logic          wrap;
  logic          ramp_entry;
  logic          step_end;

  assign ramp_entry = (state == DISCHARGE) && (dis_cnt == LAST_DISCHARGE);
  assign step_end   = (state == RAMP) && wrap && (per_cnt == LAST_PERIOD);

  pwm_dac #(
    .CODE_WIDTH(CODE_WIDTH)
  ) u_pwm_dac (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state != IDLE),
    .clear   (ramp_entry),
    .active  (state == RAMP),
    .code    (ramp_code),
    .pwm_out (pwm_out),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      per_cnt    <= '0;
      dis_cnt    <= '0;
      first_ramp <= 1'b0;
      ramp_code  <= '0;
      adc_code   <= '0;
      code_valid <= 1'b0;
      overrange  <= 1'b0;
      underrange <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: pulse outputs take a default at the top of the block and are
      // overridden below, so they can never stick high for a second cycle.
      code_valid <= 1'b0;
      first_ramp <= 1'b0;

      case (state)
        IDLE: begin
          ramp_code <= '0;
          per_cnt   <= '0;
          dis_cnt   <= '0;
          if (enable) begin
            state <= DISCHARGE;
            busy  <= 1'b1;
          end
        end

        DISCHARGE: begin
          if (ramp_entry) begin
            state      <= RAMP;
            dis_cnt    <= '0;
            per_cnt    <= '0;
            first_ramp <= 1'b1;
          end else begin
            dis_cnt <= dis_cnt + 1'b1;
          end
        end

        RAMP: begin
          // Priority: underrange, then a crossing, then end of full scale.
          if (first_ramp && vcompare_sync) begin
            adc_code   <= '0;
            underrange <= 1'b1;
            overrange  <= 1'b0;
            code_valid <= 1'b1;
            state      <= DONE;
          end else if (low_to_high_pulse) begin
            adc_code   <= ramp_code;
            underrange <= 1'b0;
            overrange  <= 1'b0;
            code_valid <= 1'b1;
            state      <= DONE;
          end else if (step_end && (ramp_code == MAX_CODE)) begin
            adc_code   <= MAX_CODE;
            underrange <= 1'b0;
            overrange  <= 1'b1;
            code_valid <= 1'b1;
            state      <= DONE;
          end else if (step_end) begin
            per_cnt   <= '0;
            ramp_code <= ramp_code + 1'b1;
          end else if (wrap) begin
            per_cnt <= per_cnt + 1'b1;
          end
        end

        DONE: begin
          ramp_code <= '0;
          per_cnt   <= '0;
          dis_cnt   <= '0;
          if (enable) begin
            state <= DISCHARGE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramp_adc_ctrl.sv
// Directed bench for ramp_adc_ctrl with CODE_WIDTH=4, STEP_PERIODS=2,
// DISCHARGE_CYCLES=16: each code is held 32 clk, a full ramp is 512 clk.
module tb_ramp_adc_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          vcompare_sync = 1'b0;
  logic          low_to_high_pulse = 1'b0;
  logic          pwm_out;
  logic [CW-1:0] ramp_code;
  logic [CW-1:0] adc_code;
  logic          code_valid;
  logic          overrange;
  logic          underrange;
  logic          busy;

  int passed = 0;
  int total  = 0;

  ramp_adc_ctrl #(
    .CODE_WIDTH      (CW),
    .STEP_PERIODS    (2),
    .DISCHARGE_CYCLES(16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .vcompare_sync    (vcompare_sync),
    .low_to_high_pulse(low_to_high_pulse),
    .pwm_out          (pwm_out),
    .ramp_code        (ramp_code),
    .adc_code         (adc_code),
    .code_valid       (code_valid),
    .overrange        (overrange),
    .underrange       (underrange),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // From IDLE: raise enable, land on the first RAMP cycle (17 falling edges).
  task automatic start_to_ramp(input bit keep_enable);
    enable = 1'b1;
    tick(1);
    if (!keep_enable) enable = 1'b0;
    tick(16);
  endtask

  // Pulse during the current cycle; returns observing the DONE cycle.
  task automatic pulse_now();
    low_to_high_pulse = 1'b1;
    tick(1);
    low_to_high_pulse = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({pwm_out, ramp_code, adc_code, code_valid, overrange, underrange, busy} !== '0)
      $display("FAIL reset_outputs: got %b want all zero",
               {pwm_out, ramp_code, adc_code, code_valid, overrange, underrange, busy});
    else passed++;
    tick(1);
    reset_n = 1'b1;
    tick(3);
    total++;
    if (busy !== 1'b0 || pwm_out !== 1'b0)
      $display("FAIL idle_no_enable: busy=%b pwm=%b want 0 0", busy, pwm_out);
    else passed++;
  endtask

  task automatic test_pulse();
    start_to_ramp(1'b0);
    total++;
    if (busy !== 1'b1 || ramp_code !== 4'd0)
      $display("FAIL ramp_start: busy=%b code=%0d want 1 0", busy, ramp_code);
    else passed++;
    tick(9 * 32 + 5);
    total++;
    if (ramp_code !== 4'd9) $display("FAIL step9_code: got %0d want 9", ramp_code);
    else passed++;
    pulse_now();
    total++;
    if (code_valid !== 1'b1 || adc_code !== 4'd9 || overrange !== 1'b0 || underrange !== 1'b0)
      $display("FAIL pulse_result: valid=%b adc=%0d ovr=%b und=%b want 1 9 0 0",
               code_valid, adc_code, overrange, underrange);
    else passed++;
    tick(1);
    total++;
    if (code_valid !== 1'b0 || busy !== 1'b0 || pwm_out !== 1'b0 || adc_code !== 4'd9)
      $display("FAIL pulse_after: valid=%b busy=%b pwm=%b adc=%0d want 0 0 0 9",
               code_valid, busy, pwm_out, adc_code);
    else passed++;
  endtask

  task automatic test_overrange();
    int n;
    n = 0;
    start_to_ramp(1'b0);
    for (int i = 1; i <= 600; i++) begin
      tick(1);
      if (code_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    total++;
    if (n !== 512) $display("FAIL overrange_latency: got %0d clk want 512", n);
    else passed++;
    total++;
    if (adc_code !== 4'd15 || overrange !== 1'b1 || underrange !== 1'b0)
      $display("FAIL overrange_result: adc=%0d ovr=%b und=%b want 15 1 0",
               adc_code, overrange, underrange);
    else passed++;
    tick(1);
  endtask

  task automatic test_underrange();
    vcompare_sync = 1'b1;
    start_to_ramp(1'b0);
    total++;
    if (code_valid !== 1'b0 || adc_code !== 4'd15)
      $display("FAIL underrange_hold: valid=%b adc=%0d want 0 15", code_valid, adc_code);
    else passed++;
    pulse_now();
    vcompare_sync = 1'b0;
    total++;
    if (code_valid !== 1'b1 || adc_code !== 4'd0 || underrange !== 1'b1 || overrange !== 1'b0)
      $display("FAIL underrange_result: valid=%b adc=%0d und=%b ovr=%b want 1 0 1 0",
               code_valid, adc_code, underrange, overrange);
    else passed++;
    tick(1);
  endtask

  task automatic test_boundary_pulse();
    start_to_ramp(1'b0);
    tick(511);
    total++;
    if (ramp_code !== 4'd15) $display("FAIL boundary_code: got %0d want 15", ramp_code);
    else passed++;
    pulse_now();
    total++;
    if (code_valid !== 1'b1 || adc_code !== 4'd15 || overrange !== 1'b0 || underrange !== 1'b0)
      $display("FAIL boundary_result: valid=%b adc=%0d ovr=%b und=%b want 1 15 0 0",
               code_valid, adc_code, overrange, underrange);
    else passed++;
    tick(1);
  endtask

  task automatic test_pwm();
    int highs;
    start_to_ramp(1'b0);
    highs = 0;
    for (int i = 0; i <= 32; i++) begin
      if (pwm_out === 1'b1) highs++;
      if (i < 32) tick(1);
    end
    total++;
    if (highs !== 0) $display("FAIL pwm_code0: got %0d high clk want 0", highs);
    else passed++;
    tick(161 - 32);
    total++;
    if (ramp_code !== 4'd5) $display("FAIL pwm_code5_code: got %0d want 5", ramp_code);
    else passed++;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      if (pwm_out === 1'b1) highs++;
      tick(1);
    end
    total++;
    if (highs !== 5) $display("FAIL pwm_code5_duty: got %0d high clk want 5", highs);
    else passed++;
    pulse_now();
    total++;
    if (adc_code !== 4'd5) $display("FAIL pwm_result: got %0d want 5", adc_code);
    else passed++;
    tick(1);
  endtask

  task automatic test_enable_drop();
    start_to_ramp(1'b1);
    tick(3 * 32);
    enable = 1'b0;
    tick(7 * 32 + 10 - 3 * 32);
    total++;
    if (ramp_code !== 4'd7 || busy !== 1'b1 || adc_code !== 4'd5)
      $display("FAIL drop_midway: code=%0d busy=%b adc=%0d want 7 1 5",
               ramp_code, busy, adc_code);
    else passed++;
    pulse_now();
    total++;
    if (code_valid !== 1'b1 || adc_code !== 4'd7)
      $display("FAIL drop_result: valid=%b adc=%0d want 1 7", code_valid, adc_code);
    else passed++;
    tick(1);
    total++;
    if (busy !== 1'b0 || pwm_out !== 1'b0 || ramp_code !== 4'd0)
      $display("FAIL drop_idle: busy=%b pwm=%b code=%0d want 0 0 0", busy, pwm_out, ramp_code);
    else passed++;
    tick(40);
    total++;
    if (busy !== 1'b0 || code_valid !== 1'b0)
      $display("FAIL drop_stays_idle: busy=%b valid=%b want 0 0", busy, code_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    start_to_ramp(1'b1);
    tick(6 * 32 + 3);
    total++;
    if (ramp_code !== 4'd6) $display("FAIL midreset_code: got %0d want 6", ramp_code);
    else passed++;
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({pwm_out, ramp_code, adc_code, code_valid, overrange, underrange, busy} !== '0)
      $display("FAIL midreset_async: got %b want all zero",
               {pwm_out, ramp_code, adc_code, code_valid, overrange, underrange, busy});
    else passed++;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    total++;
    if (busy !== 1'b1 || ramp_code !== 4'd0)
      $display("FAIL midreset_restart: busy=%b code=%0d want 1 0", busy, ramp_code);
    else passed++;
    enable = 1'b0;
    tick(16 + 32);
    total++;
    if (ramp_code !== 4'd1) $display("FAIL midreset_fresh: got %0d want 1", ramp_code);
    else passed++;
    pulse_now();
    total++;
    if (code_valid !== 1'b1 || adc_code !== 4'd1)
      $display("FAIL midreset_result: valid=%b adc=%0d want 1 1", code_valid, adc_code);
    else passed++;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_overrange();
    test_underrange();
    test_boundary_pulse();
    test_pwm();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
